moving_average_filter: RTL

Boxcar moving-average filter on a streamed ADC sample path, with a runtime-selectable power-of-two window. It sits directly upstream of the timed threshold feedback stage. That stage needs a de-noised input so single-sample spikes do not trigger feedback. Output is the window mean, truncated toward minus infinity, with a valid pulse per accepted sample once the window is full.

---
 rtl/filter_pkg.sv | 21 ++
 rtl/sample_ring_buffer.sv | 30 +++
 rtl/moving_average_filter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared sizing and window helpers for the moving-average filter
package filter_pkg;

  localparam int DEFAULT_LOG2_WINDOW_MAX = 6;
  localparam int RING_DEPTH              = 1 << DEFAULT_LOG2_WINDOW_MAX;

  // Accumulator is wide enough to hold the sum of a full window without overflow
  function automatic int acc_width(input int data_width, input int log2_window_max);
    return data_width + log2_window_max;
  endfunction

  function automatic int ring_depth(input int log2_window_max);
    return 1 << log2_window_max;
  endfunction

  // Out-of-range window selections saturate at the largest supported window
  function automatic int clamp_window(input int k, input int kmax);
    return (k > kmax) ? kmax : k;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - sample history ring with asynchronous read-before-write port
module sample_ring_buffer
  import filter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = ring_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write on the clock edge; contents need no reset because they are only read once the window is full
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read returns the pre-write value even when rd_addr equals wr_addr
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/moving_average_filter.sv
// rtl/moving_average_filter.sv - boxcar moving average with runtime power-of-two window
module moving_average_filter
  import filter_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int LOG2_WINDOW_MAX = 6,
  parameter bit IS_SIGNED       = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [$clog2(LOG2_WINDOW_MAX+1)-1:0] log2Window,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 filled
);

  localparam int KW   = $clog2(LOG2_WINDOW_MAX + 1);
  localparam int AW   = LOG2_WINDOW_MAX;
  localparam int CW   = LOG2_WINDOW_MAX + 1;
  localparam int ACCW = acc_width(DATA_WIDTH, LOG2_WINDOW_MAX);

  logic [KW-1:0]         kr;
  logic [KW-1:0]         k_clamped;
  logic                  flush;
  logic                  accept;
  logic                  full_now;
  logic [CW-1:0]         win;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] old_val;
  logic [ACCW-1:0]       new_s1;
  logic [ACCW-1:0]       old_s1;
  logic [ACCW-1:0]       acc;
  logic signed [ACCW-1:0] acc_signed;
  logic [DATA_WIDTH-1:0] acc_shift;
  logic                  v1;
  logic                  f1;
  logic                  v2;
  logic                  f2;

  function automatic logic [ACCW-1:0] extend(input logic [DATA_WIDTH-1:0] d);
    if (IS_SIGNED) begin
      return {{LOG2_WINDOW_MAX{d[DATA_WIDTH-1]}}, d};
    end
    return {{LOG2_WINDOW_MAX{1'b0}}, d};
  endfunction

  // Window selection, flush detection, saturating count and oldest-sample address
  always_comb begin
    k_clamped = KW'(clamp_window(int'(log2Window), LOG2_WINDOW_MAX));
    flush     = (k_clamped != kr);
    accept    = in_valid && !flush;
    win       = CW'(1) << kr;
    full_now  = (cnt == win);
    cnt_next  = full_now ? cnt : cnt + CW'(1);
    // For the maximum window the low bits of win are zero, so the read lands on wp itself
    rd_addr   = wp - win[AW-1:0];
    old_val   = full_now ? rd_data : '0;
  end

  // Mean is the accumulator shifted by the window; arithmetic shift floors negative sums
  always_comb begin
    acc_signed = acc;
    if (IS_SIGNED) begin
      acc_shift = DATA_WIDTH'(acc_signed >>> kr);
    end else begin
      acc_shift = DATA_WIDTH'(acc >> kr);
    end
  end

  sample_ring_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ring (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wp),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Three-stage pipeline: capture new/old, accumulate, shift into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      kr        <= '0;
      cnt       <= '0;
      wp        <= '0;
      acc       <= '0;
      new_s1    <= '0;
      old_s1    <= '0;
      v1        <= 1'b0;
      f1        <= 1'b0;
      v2        <= 1'b0;
      f2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      filled    <= 1'b0;
    end else if (flush) begin
      // New window: restart history and drop anything in flight; out_data keeps its last mean
      kr        <= k_clamped;
      cnt       <= '0;
      wp        <= '0;
      acc       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      filled    <= 1'b0;
    end else begin
      if (accept) begin
        wp     <= wp + AW'(1);
        cnt    <= cnt_next;
        new_s1 <= extend(in_data);
        old_s1 <= extend(old_val);
        f1     <= (cnt_next == win);
      end
      v1 <= accept;
      if (v1) begin
        acc <= acc + new_s1 - old_s1;
        f2  <= f1;
      end
      v2        <= v1;
      out_valid <= v2 && f2;
      if (v2 && f2) begin
        out_data <= acc_shift;
        filled   <= 1'b1;
      end
    end
  end

endmodule
